c_bus_writeback: RTL and testbench
==================================

// Module: c_bus_writeback
// PURPOSE
//  Write-back end of the datapath buses: takes the 24-bit ALU result on C_bus and
//  decodes C_bus_ctrl into a write enable for one register. Holds the registers
//  (MDR, PC, L, C1, C2, C3, T, E) whose outputs drive the B-bus source mux.
//  Also handles PC/counter auto-increment, MDR loads from data memory and a write-ack pulse.
// PARAMETERS
//  DATA_W  24  width of L, C1, C2, C3, T, E and C_bus
//  NARROW_W 8  width of PC and MDR
// PORTS
//  clk         in   1        single clock; all state updates on rising edge
//  reset       in   1        synchronous, active-high
//  C_bus       in   DATA_W   write-back data from ALU
//  C_bus_ctrl  in   4        destination select (codes below)
//  inc_ctrl    in   4        {inc_C3, inc_C2, inc_C1, inc_PC}, +1 enables
//  mem_valid   in   1        data-memory read data valid this cycle
//  mem_data    in   NARROW_W data-memory read data -> MDR
//  L,C1,C2,C3,T,E out DATA_W register outputs to B-bus mux
//  PC, MDR     out  NARROW_W register outputs
//  wr_ack      out  1        1-cycle pulse: a C-bus write committed last edge
//  wr_err      out  1        sticky: write attempted to read-only/undefined code
// BEHAVIOUR
//  - reset (sync, active-high): every register, wr_ack and wr_err are 0 at the next edge.
//    reset overrides all other inputs in the same cycle. A write or increment in
//    progress is dropped.
//  - C_bus_ctrl codes: 0000 none; 0001 MDR; 0010 PC; 0011 MBRU (read-only, no write,
//    sets wr_err); 0100 L; 0101 C1; 0110 C2; 0111 C3; 1000 T; 1001 E;
//    1010-1111 undefined (no write, sets wr_err). B-bus select uses the same encoding.
//  - Latency: a write presented in cycle n is visible on the outputs after edge n+1.
//    There is no combinational path from C_bus to the outputs.
//  - Narrow destinations (PC, MDR) take C_bus[NARROW_W-1:0]. The upper bits are ignored.
//  - Increment: a register with its inc bit set becomes reg+1 modulo 2^width
//    (PC 8'hFF->8'h00; C1 24'hFFFFFF->0). Several inc bits may be set in the same cycle.
//  - Priority per register: reset > C-bus write > increment > hold.
//    Write and inc to the same register in one cycle -> the written value, with no +1.
//  - MDR priority: reset > C-bus write (0001) > mem_valid load > hold.
//  - wr_ack = 1 for exactly one cycle after each edge that committed a valid write
//    (codes 0001, 0010, 0100-1001). Increments and mem loads do not pulse wr_ack.
//  - wr_err sets on any cycle with an illegal code and stays set until reset.
//  - Back-to-back writes every cycle are legal. wr_ack then stays high continuously.
// STRUCTURE
//  - Shared package/header: C-bus/B-bus select codes (CB_NONE, CB_MDR, CB_PC,
//    CB_MBRU, CB_L, CB_C1, CB_C2, CB_C3, CB_T, CB_E) and DATA_W/NARROW_W defaults.
//  - One sub-module wb_reg #(W): sync reset, load (data), inc, priority load>inc.
//    Instantiated 8 times. MDR uses an external mux for C-bus vs mem_data select.
//  - The top level holds the 4-to-16 write decoder, the wr_ack/wr_err flops and the wb_reg instances.
// TESTING
//  1 reset high 2 cycles with C_bus_ctrl=0100, C_bus=24'h123456 -> all outputs 0, wr_ack 0.
//  2 C_bus_ctrl=0101, C_bus=24'hABCDEF one cycle -> C1=ABCDEF next cycle,
//    wr_ack 1 for one cycle, other registers unchanged.
//  3 PC=8'hFF, inc_ctrl=0001 -> PC=8'h00. Same cycle C_bus_ctrl=0010, C_bus=24'hFFFF42
//    with inc_PC=1 -> PC=8'h42 (write wins, upper bits dropped).
//  4 C_bus_ctrl=0001, C_bus=..07 with mem_valid=1, mem_data=8'h99 -> MDR=8'h07.
//    Next cycle mem_valid only -> MDR=8'h99, wr_ack 0.
//  5 C_bus_ctrl=0011 then 1110 -> no register changes, wr_err=1 and stays 1 until reset.
//  6 Writes to L,C1,C2,C3,T,E on consecutive cycles with distinct data, and reset
//    asserted mid-sequence -> the values before reset are correct, then all 0; wr_ack drops.

Source files
------------

// File: rtl/c_bus_writeback_pkg.sv
// Shared definitions for the C-bus write-back block: bus select codes and default widths.
// The B-bus source mux uses the same select encoding.
package c_bus_writeback_pkg;

   localparam int unsigned DATA_W_DEF   = 24;
   localparam int unsigned NARROW_W_DEF = 8;

   typedef enum logic [3:0] {
      CB_NONE = 4'b0000,
      CB_MDR  = 4'b0001,
      CB_PC   = 4'b0010,
      CB_MBRU = 4'b0011,
      CB_L    = 4'b0100,
      CB_C1   = 4'b0101,
      CB_C2   = 4'b0110,
      CB_C3   = 4'b0111,
      CB_T    = 4'b1000,
      CB_E    = 4'b1001
   } cb_sel_e;

   // Codes that commit a register write; MBRU and 1010-1111 are not writable.
   function automatic logic cb_is_write(input logic [3:0] code);
      return (code == CB_MDR) || (code == CB_PC) ||
             ((code >= CB_L) && (code <= CB_E));
   endfunction

endpackage

// File: rtl/c_bus_writeback_wb_reg.sv
// Single write-back register: synchronous reset, parallel load, +1 increment.
// Load takes priority over increment; increment wraps modulo 2^W.
module wb_reg #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] data,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= data;
      end else if (inc) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/c_bus_writeback.sv
// Write-back end of the datapath: decodes C_bus_ctrl into one register write enable,
// holds MDR/PC/L/C1/C2/C3/T/E, and reports committed writes (wr_ack) and illegal codes (wr_err).
module c_bus_writeback
   import c_bus_writeback_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned NARROW_W = NARROW_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   C_bus,
   input  logic [3:0]          C_bus_ctrl,
   input  logic [3:0]          inc_ctrl,
   input  logic                mem_valid,
   input  logic [NARROW_W-1:0] mem_data,
   output logic [DATA_W-1:0]   L,
   output logic [DATA_W-1:0]   C1,
   output logic [DATA_W-1:0]   C2,
   output logic [DATA_W-1:0]   C3,
   output logic [DATA_W-1:0]   T,
   output logic [DATA_W-1:0]   E,
   output logic [NARROW_W-1:0] PC,
   output logic [NARROW_W-1:0] MDR,
   output logic                wr_ack,
   output logic                wr_err
);

   logic we_mdr, we_pc, we_l, we_c1, we_c2, we_c3, we_t, we_e;
   logic bad_code;
   logic cb_write;
   logic                mdr_load;
   logic [NARROW_W-1:0] mdr_data;
   logic [NARROW_W-1:0] c_bus_narrow;

   assign c_bus_narrow = C_bus[NARROW_W-1:0];

   // Destination decoder: at most one enable per cycle.
   always_comb begin
      we_mdr   = 1'b0;
      we_pc    = 1'b0;
      we_l     = 1'b0;
      we_c1    = 1'b0;
      we_c2    = 1'b0;
      we_c3    = 1'b0;
      we_t     = 1'b0;
      we_e     = 1'b0;
      bad_code = 1'b0;
      case (C_bus_ctrl)
         CB_NONE: ;
         CB_MDR:  we_mdr   = 1'b1;
         CB_PC:   we_pc    = 1'b1;
         CB_MBRU: bad_code = 1'b1;
         CB_L:    we_l     = 1'b1;
         CB_C1:   we_c1    = 1'b1;
         CB_C2:   we_c2    = 1'b1;
         CB_C3:   we_c3    = 1'b1;
         CB_T:    we_t     = 1'b1;
         CB_E:    we_e     = 1'b1;
         default: bad_code = 1'b1;
      endcase
   end

   assign cb_write = cb_is_write(C_bus_ctrl);

   // MDR: a C-bus write outranks a memory load arriving in the same cycle.
   always_comb begin
      mdr_load = we_mdr | mem_valid;
      mdr_data = we_mdr ? c_bus_narrow : mem_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_ack <= cb_write;
         wr_err <= wr_err | bad_code;
      end
   end

   wb_reg #(.W(NARROW_W)) u_mdr (
      .clk(clk), .reset(reset), .load(mdr_load), .data(mdr_data), .inc(1'b0), .q(MDR)
   );

   wb_reg #(.W(NARROW_W)) u_pc (
      .clk(clk), .reset(reset), .load(we_pc), .data(c_bus_narrow), .inc(inc_ctrl[0]), .q(PC)
   );

   wb_reg #(.W(DATA_W)) u_l (
      .clk(clk), .reset(reset), .load(we_l), .data(C_bus), .inc(1'b0), .q(L)
   );

   wb_reg #(.W(DATA_W)) u_c1 (
      .clk(clk), .reset(reset), .load(we_c1), .data(C_bus), .inc(inc_ctrl[1]), .q(C1)
   );

   wb_reg #(.W(DATA_W)) u_c2 (
      .clk(clk), .reset(reset), .load(we_c2), .data(C_bus), .inc(inc_ctrl[2]), .q(C2)
   );

   wb_reg #(.W(DATA_W)) u_c3 (
      .clk(clk), .reset(reset), .load(we_c3), .data(C_bus), .inc(inc_ctrl[3]), .q(C3)
   );

   wb_reg #(.W(DATA_W)) u_t (
      .clk(clk), .reset(reset), .load(we_t), .data(C_bus), .inc(1'b0), .q(T)
   );

   wb_reg #(.W(DATA_W)) u_e (
      .clk(clk), .reset(reset), .load(we_e), .data(C_bus), .inc(1'b0), .q(E)
   );

endmodule

// File: tb/tb_c_bus_writeback.sv
// Scoreboard bench for c_bus_writeback: expected register state is computed and queued
// when each cycle's stimulus is driven, then popped and compared after the clock edge.
module tb_c_bus_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] C_bus;
   logic [3:0]  C_bus_ctrl;
   logic [3:0]  inc_ctrl;
   logic        mem_valid;
   logic [7:0]  mem_data;
   logic [23:0] L, C1, C2, C3, T, E;
   logic [7:0]  PC, MDR;
   logic        wr_ack, wr_err;

   typedef struct {
      logic [23:0] l, c1, c2, c3, t, e;
      logic [7:0]  pc, mdr;
      logic        ack, err;
   } exp_t;

   exp_t m;
   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   c_bus_writeback #(.DATA_W(24), .NARROW_W(8)) dut (
      .clk(clk), .reset(reset), .C_bus(C_bus), .C_bus_ctrl(C_bus_ctrl),
      .inc_ctrl(inc_ctrl), .mem_valid(mem_valid), .mem_data(mem_data),
      .L(L), .C1(C1), .C2(C2), .C3(C3), .T(T), .E(E),
      .PC(PC), .MDR(MDR), .wr_ack(wr_ack), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference next state, written from the behavioural description.
   task automatic model_step(input logic rst, input logic [3:0] ctrl, input logic [23:0] cb,
                             input logic [3:0] inc, input logic mv, input logic [7:0] md);
      exp_t n;
      n = m;
      if (rst) begin
         n.l = 0; n.c1 = 0; n.c2 = 0; n.c3 = 0; n.t = 0; n.e = 0;
         n.pc = 0; n.mdr = 0; n.ack = 0; n.err = 0;
      end else begin
         n.ack = (ctrl == 1) || (ctrl == 2) || (ctrl >= 4 && ctrl <= 9);
         n.err = m.err | (ctrl == 3) | (ctrl >= 10);
         if (ctrl == 1)      n.mdr = cb[7:0];
         else if (mv)        n.mdr = md;
         if (ctrl == 2)      n.pc = cb[7:0];
         else if (inc[0])    n.pc = m.pc + 8'd1;
         if (ctrl == 4)      n.l = cb;
         if (ctrl == 5)      n.c1 = cb;
         else if (inc[1])    n.c1 = m.c1 + 24'd1;
         if (ctrl == 6)      n.c2 = cb;
         else if (inc[2])    n.c2 = m.c2 + 24'd1;
         if (ctrl == 7)      n.c3 = cb;
         else if (inc[3])    n.c3 = m.c3 + 24'd1;
         if (ctrl == 8)      n.t = cb;
         if (ctrl == 9)      n.e = cb;
      end
      m = n;
      sb_q.push_back(n);
   endtask

   task automatic compare_out();
      exp_t x;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      x = sb_q.pop_front();
      check("L",      {8'h0, L},   {8'h0, x.l});
      check("C1",     {8'h0, C1},  {8'h0, x.c1});
      check("C2",     {8'h0, C2},  {8'h0, x.c2});
      check("C3",     {8'h0, C3},  {8'h0, x.c3});
      check("T",      {8'h0, T},   {8'h0, x.t});
      check("E",      {8'h0, E},   {8'h0, x.e});
      check("PC",     {24'h0, PC},  {24'h0, x.pc});
      check("MDR",    {24'h0, MDR}, {24'h0, x.mdr});
      check("wr_ack", {31'h0, wr_ack}, {31'h0, x.ack});
      check("wr_err", {31'h0, wr_err}, {31'h0, x.err});
   endtask

   task automatic step(input logic rst, input logic [3:0] ctrl, input logic [23:0] cb,
                       input logic [3:0] inc, input logic mv, input logic [7:0] md);
      reset = rst; C_bus_ctrl = ctrl; C_bus = cb; inc_ctrl = inc;
      mem_valid = mv; mem_data = md;
      model_step(rst, ctrl, cb, inc, mv, md);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      m = '{default: '0};
      // Reset overrides a pending write to L.
      step(1'b1, 4'b0100, 24'h123456, 4'b0000, 1'b0, 8'h00);
      step(1'b1, 4'b0100, 24'h123456, 4'b0000, 1'b0, 8'h00);
      check("reset_L_direct", {8'h0, L}, 32'h0);
      // Single C1 write, then idle so wr_ack drops.
      step(1'b0, 4'b0101, 24'hABCDEF, 4'b0000, 1'b0, 8'h00);
      check("c1_direct", {8'h0, C1}, 32'h00ABCDEF);
      step(1'b0, 4'b0000, 24'h000000, 4'b0000, 1'b0, 8'h00);
      // PC wrap, then write beats increment with upper bits dropped.
      step(1'b0, 4'b0010, 24'h0000FF, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0000, 24'h000000, 4'b0001, 1'b0, 8'h00);
      check("pc_wrap_direct", {24'h0, PC}, 32'h0);
      step(1'b0, 4'b0010, 24'hFFFF42, 4'b0001, 1'b0, 8'h00);
      check("pc_write_wins", {24'h0, PC}, 32'h42);
      // MDR: C-bus write beats mem load, then mem load alone.
      step(1'b0, 4'b0001, 24'h000007, 4'b0000, 1'b1, 8'h99);
      check("mdr_cbus", {24'h0, MDR}, 32'h07);
      step(1'b0, 4'b0000, 24'h000000, 4'b0000, 1'b1, 8'h99);
      check("mdr_mem", {24'h0, MDR}, 32'h99);
      check("mdr_mem_noack", {31'h0, wr_ack}, 32'h0);
      // 24-bit wrap and several increments together.
      step(1'b0, 4'b0101, 24'hFFFFFF, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0000, 24'h000000, 4'b1111, 1'b0, 8'h00);
      check("c1_wrap", {8'h0, C1}, 32'h0);
      step(1'b0, 4'b0110, 24'h00F00D, 4'b1110, 1'b0, 8'h00);
      // Illegal codes: MBRU then undefined; error stays sticky.
      step(1'b0, 4'b0011, 24'h555555, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b1110, 24'h666666, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0000, 24'h000000, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0100, 24'h010203, 4'b0000, 1'b0, 8'h00);
      check("err_sticky", {31'h0, wr_err}, 32'h1);
      // Back-to-back writes with reset in the middle.
      step(1'b0, 4'b0100, 24'h111111, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0101, 24'h222222, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0110, 24'h333333, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0111, 24'h444444, 4'b0000, 1'b0, 8'h00);
      check("b2b_ack", {31'h0, wr_ack}, 32'h1);
      step(1'b1, 4'b1000, 24'h555555, 4'b1111, 1'b1, 8'hAA);
      step(1'b0, 4'b1001, 24'h666666, 4'b0000, 1'b0, 8'h00);
      step(1'b0, 4'b0000, 24'h000000, 4'b0000, 1'b0, 8'h00);
      // Random traffic over all codes, increments and memory loads.
      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), 24'($urandom),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
